// File: rtl/calendar_engine_if.sv
// calendar_engine_if
//   Groups the calendar's stimulus and status signals.
//   master : timekeeping/host side; drives tick and the load request,
//            observes the current date and status.
//   slave  : calendar_engine side.
//   Signals:
//     tick                          advance one day (single-cycle pulse)
//     load, load_year/month/day     date load request and payload
//     year, month, day, day_of_week current date
//     leap, dow_valid, busy         status
//     load_err, month_wrap,
//     year_wrap                     one-cycle event pulses
//     pend_ovf                      sticky lost-tick flag
interface calendar_engine_if #(
  parameter int YEAR_W = 15
);
  logic              tick;
  logic              load;
  logic [YEAR_W-1:0] load_year;
  logic [3:0]        load_month;
  logic [4:0]        load_day;
  logic [YEAR_W-1:0] year;
  logic [3:0]        month;
  logic [4:0]        day;
  logic [2:0]        day_of_week;
  logic              leap;
  logic              dow_valid;
  logic              busy;
  logic              load_err;
  logic              month_wrap;
  logic              year_wrap;
  logic              pend_ovf;

  modport master (
    output tick, load, load_year, load_month, load_day,
    input  year, month, day, day_of_week, leap, dow_valid, busy,
           load_err, month_wrap, year_wrap, pend_ovf
  );

  modport slave (
    input  tick, load, load_year, load_month, load_day,
    output year, month, day, day_of_week, leap, dow_valid, busy,
           load_err, month_wrap, year_wrap, pend_ovf
  );
endinterface

// File: rtl/calendar_engine.sv
// calendar_engine
//   Day/month/year calendar with Gregorian leap rules, a validated date
//   load, and a multi-cycle day-of-week recompute after each load.
//   Ticks that arrive while the recompute runs are buffered and replayed.
//   Ports:
//     clk  system clock
//     rst  synchronous active-high reset
//     bus  calendar_engine_if.slave (tick/load in, date/status out)
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   S_IDLE   | date valid; ticks and buffered ticks advance the date
//   S_YEARS  | accumulate weekday offset over years BASE_YEAR..year-1
//   S_MONTHS | accumulate weekday offset over months 1..month-1
//   S_FINISH | add day offset, publish day_of_week
module calendar_engine #(
  parameter int YEAR_W    = 15,
  parameter int BASE_YEAR = 2000,
  parameter int BASE_DOW  = 6,
  parameter int PEND_W    = 4
) (
  input logic clk,
  input logic rst,
  calendar_engine_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_YEARS  = 2'd1;
  localparam logic [1:0] S_MONTHS = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [YEAR_W-1:0] BASE_Y   = YEAR_W'(BASE_YEAR);
  localparam logic [YEAR_W-1:0] MAX_Y    = '1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    return ((y % 4) == 0 && (y % 100) != 0) || (y % 400) == 0;
  endfunction

  function automatic logic [4:0] dim(input logic [YEAR_W-1:0] y, input logic [3:0] m);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      4'd2:                    dim = is_leap(y) ? 5'd29 : 5'd28;
      default:                 dim = 5'd31;
    endcase
  endfunction

  function automatic logic [2:0] mod7(input logic [5:0] v);
    return 3'(v % 6'd7);
  endfunction

  logic [1:0]        state;
  logic [YEAR_W-1:0] year, yc;
  logic [3:0]        month, mc;
  logic [4:0]        day;
  logic [2:0]        dow, acc;
  logic              dow_valid, load_err, month_wrap, year_wrap, pend_ovf;
  logic [PEND_W-1:0] pending;

  logic load_ok, idle, step, at_max, tick_lost;
  logic [4:0] cur_dim;

  assign idle    = (state == S_IDLE);
  assign cur_dim = dim(year, month);
  assign at_max  = (year == MAX_Y) && (month == 4'd12) && (day == 5'd31);

  assign load_ok = bus.load && (bus.load_year >= BASE_Y) &&
                   (bus.load_month >= 4'd1) && (bus.load_month <= 4'd12) &&
                   (bus.load_day != 5'd0) &&
                   (bus.load_day <= dim(bus.load_year, bus.load_month));

  // An accepted load takes the cycle, so a coincident tick is buffered.
  assign step      = idle && !load_ok && (bus.tick || pending != '0);
  assign tick_lost = bus.tick && (load_ok || !idle) && (pending == PEND_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      year       <= BASE_Y;
      month      <= 4'd1;
      day        <= 5'd1;
      dow        <= 3'(BASE_DOW);
      dow_valid  <= 1'b1;
      acc        <= 3'd0;
      yc         <= BASE_Y;
      mc         <= 4'd1;
      pending    <= '0;
      pend_ovf   <= 1'b0;
      load_err   <= 1'b0;
      month_wrap <= 1'b0;
      year_wrap  <= 1'b0;
    end else begin
      load_err   <= bus.load && !load_ok;
      month_wrap <= 1'b0;
      year_wrap  <= 1'b0;

      if (load_ok || !idle) begin
        if (bus.tick && pending != PEND_MAX)
          pending <= pending + 1'b1;
      end else if (pending != '0 && !bus.tick) begin
        pending <= pending - 1'b1;
      end

      // A tick lost in the same cycle as a load still counts as lost.
      if (load_ok)
        pend_ovf <= tick_lost;
      else if (tick_lost)
        pend_ovf <= 1'b1;

      if (load_ok) begin
        year      <= bus.load_year;
        month     <= bus.load_month;
        day       <= bus.load_day;
        dow_valid <= 1'b0;
        state     <= S_YEARS;
        acc       <= 3'(BASE_DOW);
        yc        <= BASE_Y;
      end else begin
        case (state)
          S_IDLE: begin
            if (step && !at_max) begin
              dow <= (dow == 3'd6) ? 3'd0 : dow + 3'd1;
              if (day < cur_dim) begin
                day <= day + 5'd1;
              end else begin
                day        <= 5'd1;
                month_wrap <= 1'b1;
                if (month == 4'd12) begin
                  month     <= 4'd1;
                  year      <= year + 1'b1;
                  year_wrap <= 1'b1;
                end else begin
                  month <= month + 4'd1;
                end
              end
            end
          end
          S_YEARS: begin
            if (yc < year) begin
              // 365 mod 7 = 1, plus one more for a leap year
              acc <= mod7(6'(acc) + 6'd1 + 6'(is_leap(yc)));
              yc  <= yc + 1'b1;
            end else begin
              mc    <= 4'd1;
              state <= S_MONTHS;
            end
          end
          S_MONTHS: begin
            if (mc < month) begin
              acc <= mod7(6'(acc) + 6'(dim(year, mc)));
              mc  <= mc + 4'd1;
            end else begin
              state <= S_FINISH;
            end
          end
          default: begin
            dow       <= mod7(6'(acc) + 6'(day) - 6'd1);
            dow_valid <= 1'b1;
            state     <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.year        = year;
  assign bus.month       = month;
  assign bus.day         = day;
  assign bus.day_of_week = dow;
  assign bus.leap        = is_leap(year);
  assign bus.dow_valid   = dow_valid;
  assign bus.busy        = !idle;
  assign bus.load_err    = load_err;
  assign bus.month_wrap  = month_wrap;
  assign bus.year_wrap   = year_wrap;
  assign bus.pend_ovf    = pend_ovf;

endmodule

// File: tb/tb_calendar_engine.sv
// tb_calendar_engine
//   Directed and randomized stimulus for calendar_engine, checked against a
//   date model that advances by calendar rules and derives the weekday with
//   a closed-form formula.
module tb_calendar_engine;
  localparam int YW = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  calendar_engine_if #(.YEAR_W(YW)) bus ();

  calendar_engine #(
    .YEAR_W(YW), .BASE_YEAR(2000), .BASE_DOW(6), .PEND_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int my, mm, md;
  int held_dow;
  bit exp_mw, exp_yw;

  function automatic bit m_leap(input int y);
    return (y % 4 == 0 && y % 100 != 0) || (y % 400 == 0);
  endfunction

  function automatic int m_dim(input int y, input int m);
    case (m)
      2:            return m_leap(y) ? 29 : 28;
      4, 6, 9, 11:  return 30;
      default:      return 31;
    endcase
  endfunction

  // Sakamoto's weekday formula, 0=Sun
  function automatic int m_dow(input int y, input int m, input int d);
    int t;
    int yy;
    case (m)
      1: t = 0;  2: t = 3;  3: t = 2;  4: t = 5;  5: t = 0;  6: t = 3;
      7: t = 5;  8: t = 1;  9: t = 4;  10: t = 6; 11: t = 2; default: t = 4;
    endcase
    yy = (m < 3) ? y - 1 : y;
    return (yy + yy / 4 - yy / 100 + yy / 400 + t + d) % 7;
  endfunction

  task automatic m_advance();
    exp_mw = 1'b0;
    exp_yw = 1'b0;
    if (my == 32767 && mm == 12 && md == 31) return;
    if (md < m_dim(my, mm)) begin
      md++;
    end else begin
      md     = 1;
      exp_mw = 1'b1;
      if (mm == 12) begin
        mm     = 1;
        my++;
        exp_yw = 1'b1;
      end else begin
        mm++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_date(input string tag);
    chk({tag, ".year"}, 32'(bus.year), my);
    chk({tag, ".month"}, 32'(bus.month), mm);
    chk({tag, ".day"}, 32'(bus.day), md);
    chk({tag, ".leap"}, 32'(bus.leap), 32'(m_leap(my)));
    chk({tag, ".dow"}, 32'(bus.day_of_week), m_dow(my, mm, md));
    held_dow = m_dow(my, mm, md);
  endtask

  task automatic tick_once(input string tag);
    bus.tick = 1'b1;
    cycle();
    bus.tick = 1'b0;
    m_advance();
    check_date(tag);
    chk({tag, ".month_wrap"}, 32'(bus.month_wrap), 32'(exp_mw));
    chk({tag, ".year_wrap"}, 32'(bus.year_wrap), 32'(exp_yw));
  endtask

  task automatic do_load(input int y, input int m, input int d);
    bus.load       = 1'b1;
    bus.load_year  = YW'(y);
    bus.load_month = 4'(m);
    bus.load_day   = 5'(d);
    cycle();
    bus.load = 1'b0;
    my = y; mm = m; md = d;
    chk("load.busy", 32'(bus.busy), 1);
    chk("load.dow_valid", 32'(bus.dow_valid), 0);
    chk("load.year", 32'(bus.year), my);
    chk("load.month", 32'(bus.month), mm);
    chk("load.day", 32'(bus.day), md);
    chk("load.dow_hold", 32'(bus.day_of_week), held_dow);
    chk("load.pend_ovf", 32'(bus.pend_ovf), 0);
    chk("load.load_err", 32'(bus.load_err), 0);
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40000) begin
      cycle();
      cnt++;
    end
    chk("busy_timeout", 32'(bus.busy), 0);
  endtask

  // busy is high for the state-load cycle plus (y-2000)+(m-1)+2 more, so
  // it is seen low that many+1 edges after the load is observed.
  task automatic finish_load(input string tag);
    int cnt;
    wait_idle(cnt);
    chk({tag, ".latency"}, cnt, (my - 2000) + (mm - 1) + 3);
    chk({tag, ".dow_valid"}, 32'(bus.dow_valid), 1);
    check_date(tag);
  endtask

  task automatic do_reject(input string tag, input int y, input int m, input int d);
    bus.load       = 1'b1;
    bus.load_year  = YW'(y);
    bus.load_month = 4'(m);
    bus.load_day   = 5'(d);
    cycle();
    bus.load = 1'b0;
    chk({tag, ".load_err"}, 32'(bus.load_err), 1);
    chk({tag, ".busy"}, 32'(bus.busy), 0);
    chk({tag, ".dow_valid"}, 32'(bus.dow_valid), 1);
    check_date(tag);
    cycle();
    chk({tag, ".load_err_clr"}, 32'(bus.load_err), 0);
    check_date({tag, "_next"});
  endtask

  initial begin
    int cnt, y, m, d;
    rst = 1'b1;
    bus.tick = 1'b0;
    bus.load = 1'b0;
    bus.load_year = '0;
    bus.load_month = '0;
    bus.load_day = '0;
    cycle();
    rst = 1'b0;
    my = 2000; mm = 1; md = 1;
    check_date("reset");
    chk("reset.dow_const", 32'(bus.day_of_week), 6);
    chk("reset.dow_valid", 32'(bus.dow_valid), 1);
    chk("reset.busy", 32'(bus.busy), 0);
    chk("reset.pend_ovf", 32'(bus.pend_ovf), 0);
    chk("reset.pulses", {29'd0, bus.load_err, bus.month_wrap, bus.year_wrap}, 0);

    // 365 consecutive ticks through 2000
    bus.tick = 1'b1;
    for (int i = 0; i < 365; i++) begin
      cycle();
      m_advance();
      chk("run.day", 32'(bus.day), md);
      chk("run.month_wrap", 32'(bus.month_wrap), 32'(exp_mw));
    end
    bus.tick = 1'b0;
    check_date("dec31");
    chk("dec31.const", {17'd0, bus.year, bus.month, bus.day, bus.day_of_week} >> 0,
        {17'd0, 15'd2000, 4'd12, 5'd31, 3'd0});
    tick_once("newyear");
    chk("newyear.dow", 32'(bus.day_of_week), 1);
    chk("newyear.pulses", {30'd0, bus.month_wrap, bus.year_wrap}, 3);
    cycle();
    chk("newyear.pulse_clr", {30'd0, bus.month_wrap, bus.year_wrap}, 0);

    // random ticks while idle
    for (int i = 0; i < 150; i++) begin
      bus.tick = 1'($urandom_range(0, 1));
      cycle();
      if (bus.tick) m_advance();
      else begin exp_mw = 1'b0; exp_yw = 1'b0; end
      check_date("rnd_tick");
      chk("rnd_tick.month_wrap", 32'(bus.month_wrap), 32'(exp_mw));
      chk("rnd_tick.year_wrap", 32'(bus.year_wrap), 32'(exp_yw));
    end
    bus.tick = 1'b0;
    cycle();

    // leap day in 2000, none in 2100
    do_load(2000, 2, 28);
    finish_load("l2000");
    tick_once("feb29");
    chk("feb29.leap", 32'(bus.leap), 1);
    tick_once("mar01");
    chk("mar01.month_wrap", 32'(bus.month_wrap), 1);

    do_load(2100, 2, 28);
    finish_load("l2100");
    tick_once("2100mar");
    chk("2100mar.month", 32'(bus.month), 3);
    chk("2100mar.dow", 32'(bus.day_of_week), 1);

    do_load(2024, 7, 4);
    finish_load("l2024");
    chk("l2024.dow", 32'(bus.day_of_week), 4);

    // restart mid-calculation
    do_load(2024, 7, 4);
    for (int i = 0; i < 5; i++) cycle();
    do_load(2001, 1, 1);
    finish_load("restart");
    chk("restart.dow", 32'(bus.day_of_week), 1);

    // three ticks buffered during the recompute
    do_load(2024, 7, 4);
    bus.tick = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    bus.tick = 1'b0;
    wait_idle(cnt);
    for (int i = 0; i < 3; i++) cycle();
    for (int i = 0; i < 3; i++) m_advance();
    check_date("drain3");
    chk("drain3.dow", 32'(bus.day_of_week), 0);
    for (int i = 0; i < 5; i++) cycle();
    check_date("drain3_hold");

    // 20 ticks starting with the load cycle: 15 kept, rest lost
    bus.tick = 1'b1;
    do_load(2024, 7, 4);
    for (int i = 0; i < 19; i++) cycle();
    bus.tick = 1'b0;
    chk("sat.pend_ovf", 32'(bus.pend_ovf), 1);
    wait_idle(cnt);
    for (int i = 0; i < 20; i++) cycle();
    for (int i = 0; i < 15; i++) m_advance();
    check_date("sat");
    chk("sat.day", 32'(bus.day), 19);
    chk("sat.pend_ovf_sticky", 32'(bus.pend_ovf), 1);

    // rejected loads
    do_reject("rej_feb29", 2023, 2, 29);
    do_reject("rej_1999", 1999, 5, 5);
    do_reject("rej_m13", 2020, 13, 1);
    do_reject("rej_d0", 2020, 6, 0);
    chk("rej.pend_ovf", 32'(bus.pend_ovf), 1);

    // random valid loads followed by a few ticks
    for (int i = 0; i < 6; i++) begin
      y = 2000 + int'($urandom_range(0, 500));
      m = int'($urandom_range(1, 12));
      d = int'($urandom_range(1, m_dim(y, m)));
      do_load(y, m, d);
      finish_load("rnd_load");
      for (int k = 0; k < 3; k++) tick_once("rnd_load_tick");
    end

    // random out-of-range days
    for (int i = 0; i < 3; i++) begin
      y = 2000 + int'($urandom_range(0, 500));
      m = int'($urandom_range(1, 12));
      d = (m_dim(y, m) == 31) ? 0 : m_dim(y, m) + 1;
      do_reject("rnd_rej", y, m, d);
    end

    // reset mid-calculation
    do_load(2300, 5, 5);
    for (int i = 0; i < 10; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    my = 2000; mm = 1; md = 1;
    check_date("rst_mid");
    chk("rst_mid.busy", 32'(bus.busy), 0);
    chk("rst_mid.dow_valid", 32'(bus.dow_valid), 1);
    chk("rst_mid.dow", 32'(bus.day_of_week), 6);
    tick_once("rst_mid_tick");

    // top of the year range: date holds at the maximum
    do_load(32767, 12, 30);
    finish_load("max");
    tick_once("max31");
    tick_once("max_hold");
    chk("max_hold.day", 32'(bus.day), 31);
    chk("max_hold.year", 32'(bus.year), 32767);
    tick_once("max_hold2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
